// File: rtl/afc_cal_sequencer_if.sv
// afc_cal_sequencer_if: calibration control, cap-bank code and frequency-counter handshake
interface afc_cal_sequencer_if #(
  parameter int CODE_W = 4,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [CNT_W-1:0]  target_cnt;
  logic              meas_start;
  logic              meas_done;
  logic [CNT_W-1:0]  meas_cnt;
  logic [CODE_W-1:0] cap_code;
  logic              busy;
  logic              done;
  logic              lock;
  logic              err;
  modport master (
    output start, target_cnt, meas_done, meas_cnt,
    input  meas_start, cap_code, busy, done, lock, err
  );
  modport slave (
    input  start, target_cnt, meas_done, meas_cnt,
    output meas_start, cap_code, busy, done, lock, err
  );
endinterface

// File: rtl/afc_cal_sequencer.sv
// afc_cal_sequencer: SAR search of the VCO cap code against a target count, with early lock and a final verify
module afc_cal_sequencer #(
  parameter int CODE_W      = 4,
  parameter int CNT_W       = 16,
  parameter int SETTLE_CYC  = 16,
  parameter int TOL         = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic clk,
  input logic rst,
  afc_cal_sequencer_if.slave cal
);
  localparam int PW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CODE_W-1:0] MID   = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [CNT_W:0]    TOL_V = (CNT_W+1)'(TOL);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_TRIG, S_WAIT, S_DONE} state_t;
  state_t            state_q;
  logic [CODE_W-1:0] code_q, code_dec, code_d;
  logic [PW-1:0]     ptr_q;
  logic              verify_q;
  logic [CNT_W-1:0]  tgt_q;
  logic [SW-1:0]     st_q;
  logic [TW-1:0]     to_q;
  logic              meas_start_q, busy_q, done_q, lock_q, err_q;
  logic [CNT_W:0]    diff;
  logic              slow, in_tol;
  always_comb begin
    diff     = (cal.meas_cnt >= tgt_q) ? {1'b0, cal.meas_cnt - tgt_q} : {1'b0, tgt_q - cal.meas_cnt};
    in_tol   = diff <= TOL_V;
    slow     = cal.meas_cnt < tgt_q;
    code_dec = slow ? code_q : code_q & ~(CODE_W'(1) << ptr_q);
    code_d   = code_dec | ((ptr_q != '0) ? (CODE_W'(1) << (ptr_q - 1'b1)) : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      code_q       <= MID;
      ptr_q        <= '0;
      verify_q     <= 1'b0;
      tgt_q        <= '0;
      st_q         <= '0;
      to_q         <= '0;
      meas_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lock_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      meas_start_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: if (cal.start) begin
          tgt_q    <= cal.target_cnt;
          code_q   <= MID;
          ptr_q    <= PW'(CODE_W - 1);
          verify_q <= 1'b0;
          st_q     <= '0;
          done_q   <= 1'b0;
          lock_q   <= 1'b0;
          err_q    <= 1'b0;
          busy_q   <= 1'b1;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: if (st_q == SW'(SETTLE_CYC - 1)) begin
          st_q         <= '0;
          meas_start_q <= 1'b1;
          state_q      <= S_TRIG;
        end else begin
          st_q <= st_q + 1'b1;
        end
        S_TRIG: begin
          to_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: if (cal.meas_done) begin
          // a failed verify ends the run without touching the code
          if (in_tol || verify_q) begin
            lock_q  <= in_tol;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            code_q   <= code_d;
            ptr_q    <= (ptr_q == '0) ? ptr_q : ptr_q - 1'b1;
            verify_q <= ptr_q == '0;
            state_q  <= S_SETTLE;
          end
        end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
          err_q   <= 1'b1;
          lock_q  <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end else begin
          to_q <= to_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign cal.meas_start = meas_start_q;
  assign cal.cap_code   = code_q;
  assign cal.busy       = busy_q;
  assign cal.done       = done_q;
  assign cal.lock       = lock_q;
  assign cal.err        = err_q;
endmodule

// File: tb/tb_afc_cal_sequencer.sv
// tb_afc_cal_sequencer: scoreboard bench driving the counter handshake and checking codes and final flags
module tb_afc_cal_sequencer;
  localparam int CODE_W = 4;
  localparam int CNT_W  = 16;
  localparam int SETTLE = 4;
  localparam int TO     = 64;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [CODE_W-1:0] exp_code_q[$];
  logic [CNT_W-1:0]  ans_q[$];
  logic [3:0]        exp_fin_q[$];
  always #5 clk = ~clk;
  afc_cal_sequencer_if #(.CODE_W(CODE_W), .CNT_W(CNT_W)) sb ();
  afc_cal_sequencer #(
    .CODE_W(CODE_W), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE), .TOL(2), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cal(sb)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic go(input logic [CNT_W-1:0] tgt);
    @(negedge clk);
    sb.start = 1'b1;
    sb.target_cnt = tgt;
    @(negedge clk);
    sb.start = 1'b0;
  endtask
  task automatic push(input logic [CODE_W-1:0] code, input logic [CNT_W-1:0] ans);
    exp_code_q.push_back(code);
    ans_q.push_back(ans);
  endtask
  // fin = {done, lock, err, busy}
  task automatic run(input int budget, input int st0, input bit poke);
    int n = 0;
    int stable = st0;
    int post = 0;
    bit fin = 1'b0;
    logic [CODE_W-1:0] prev = sb.cap_code;
    logic [CNT_W-1:0] a;
    while (!fin) begin
      if (sb.meas_start) begin
        chk("settle", stable >= SETTLE, 1);
        chk("busy", sb.busy, 1);
        if (exp_code_q.size() == 0) chk("extra_meas", 1, 0);
        else chk("cap_code", sb.cap_code, exp_code_q.pop_front());
        if (ans_q.size() != 0) begin
          a = ans_q.pop_front();
          @(negedge clk);
          if (poke) begin
            sb.start = 1'b1;
            sb.target_cnt = '0;
          end
          @(negedge clk);
          sb.start = 1'b0;
          sb.meas_done = 1'b1;
          sb.meas_cnt = a;
          @(negedge clk);
          sb.meas_done = 1'b0;
          stable = 0;
          prev = sb.cap_code;
          n += 3;
          continue;
        end
      end else if (sb.done) begin
        if (exp_fin_q.size() == 0) chk("final_missing", 1, 0);
        else chk("final", {sb.done, sb.lock, sb.err, sb.busy}, exp_fin_q.pop_front());
        chk("left_meas", exp_code_q.size(), 0);
        exp_code_q.delete();
        ans_q.delete();
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          post += int'(sb.meas_start);
        end
        chk("post_meas", post, 0);
        chk("done_hold", sb.done, 1);
        fin = 1'b1;
        continue;
      end
      @(negedge clk);
      n++;
      stable = (sb.cap_code == prev) ? stable + 1 : 0;
      prev = sb.cap_code;
      if (n > budget) begin
        chk("run_budget", 0, 1);
        exp_code_q.delete();
        ans_q.delete();
        exp_fin_q.delete();
        fin = 1'b1;
      end
    end
  endtask
  task automatic wait_ms(input int budget);
    int n = 0;
    while (!sb.meas_start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("ms_seen", sb.meas_start, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    sb.start = 1'b0;
    sb.target_cnt = '0;
    sb.meas_done = 1'b0;
    sb.meas_cnt = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", {sb.cap_code, sb.meas_start, sb.busy, sb.done, sb.lock, sb.err}, {4'b1000, 5'b0});
    rst = 1'b0;
    // immediate lock
    push(4'b1000, 16'd1000);
    exp_fin_q.push_back(4'b1100);
    go(16'd1000);
    run(200, 0, 1'b0);
    chk("code_lock1", sb.cap_code, 4'b1000);
    // always slow, verify inside tolerance
    push(4'b1000, 16'd900); push(4'b1100, 16'd900); push(4'b1110, 16'd900);
    push(4'b1111, 16'd900); push(4'b1111, 16'd999);
    exp_fin_q.push_back(4'b1100);
    go(16'd1000);
    run(400, 0, 1'b0);
    // always slow, verify fails
    for (int i = 0; i < 4; i++) push(4'b1000 | (4'b1111 << (3 - i)), 16'd900);
    push(4'b1111, 16'd900);
    exp_fin_q.push_back(4'b1000);
    go(16'd1000);
    run(400, 0, 1'b0);
    chk("code_slow", sb.cap_code, 4'b1111);
    // always fast
    push(4'b1000, 16'd1100); push(4'b0100, 16'd1100); push(4'b0010, 16'd1100);
    push(4'b0001, 16'd1100); push(4'b0000, 16'd1100);
    exp_fin_q.push_back(4'b1000);
    go(16'd1000);
    run(400, 0, 1'b0);
    chk("code_fast", sb.cap_code, 4'b0000);
    // tolerance edges
    push(4'b1000, 16'd1002);
    exp_fin_q.push_back(4'b1100);
    go(16'd1000);
    run(200, 0, 1'b0);
    push(4'b1000, 16'd998);
    exp_fin_q.push_back(4'b1100);
    go(16'd1000);
    run(200, 0, 1'b0);
    push(4'b1000, 16'd1003); push(4'b0100, 16'd1000);
    exp_fin_q.push_back(4'b1100);
    go(16'd1000);
    run(200, 0, 1'b0);
    chk("code_tol3", sb.cap_code, 4'b0100);
    // counter never answers
    exp_code_q.push_back(4'b1000);
    exp_fin_q.push_back(4'b1010);
    go(16'd1000);
    run(TO + 100, 0, 1'b0);
    // start and meas_done in SETTLE, start in WAIT: all ignored
    push(4'b1000, 16'd1100); push(4'b0100, 16'd1000);
    exp_fin_q.push_back(4'b1100);
    go(16'd1000);
    sb.start = 1'b1;
    sb.target_cnt = '0;
    sb.meas_done = 1'b1;
    sb.meas_cnt = 16'd1000;
    @(negedge clk);
    sb.start = 1'b0;
    sb.meas_done = 1'b0;
    run(300, 1, 1'b1);
    chk("code_ign", sb.cap_code, 4'b0100);
    // reset while waiting on the second measurement
    go(16'd1000);
    wait_ms(50);
    @(negedge clk);
    @(negedge clk);
    sb.meas_done = 1'b1;
    sb.meas_cnt = 16'd1100;
    @(negedge clk);
    sb.meas_done = 1'b0;
    wait_ms(50);
    chk("code_pre_rst", sb.cap_code, 4'b0100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst", {sb.cap_code, sb.meas_start, sb.busy, sb.done, sb.lock, sb.err}, {4'b1000, 5'b0});
    sb.meas_done = 1'b1;
    sb.meas_cnt = 16'd1000;
    @(negedge clk);
    sb.meas_done = 1'b0;
    @(negedge clk);
    chk("late_done", {sb.cap_code, sb.busy, sb.done, sb.lock}, {4'b1000, 3'b0});
    push(4'b1000, 16'd1000);
    exp_fin_q.push_back(4'b1100);
    go(16'd1000);
    run(200, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/afc_cal_sequencer.md
Name: afc_cal_sequencer

Overview:
- Sequences one automatic frequency calibration run: drives the VCO cap-bank code, waits for settling, triggers the frequency counter and reads its result.
- Runs an MSB-first successive-approximation search on the cap code, with early freeze when the count is within tolerance, then a final verify measurement.
- Sits between the calibration start/status interface and the VCO cap bank plus the frequency-counter datapath.

Parameters:
- CODE_W, 4, cap-bank code width; search starts at mid code (MSB set, rest 0).
- CNT_W, 16, width of the counter result and the target count.
- SETTLE_CYC, 16, clk cycles held after every cap_code change before triggering a measurement (>=1).
- TOL, 2, unsigned count tolerance for lock.
- TIMEOUT_CYC, 4096, max cycles waiting for meas_done before the run aborts with error.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin calibration.
- target_cnt  in  CNT_W  desired counter value; sampled on the accepted start edge.
- meas_start  out  1  one-cycle pulse that starts a counter measurement.
- meas_done  in  1  one-cycle pulse; meas_cnt is valid in the same cycle.
- meas_cnt  in  CNT_W  measured count.
- cap_code  out  CODE_W  registered code driven to the cap bank.
- busy  out  1  high from the accepted start until the run ends.
- done  out  1  level; high in DONE until the next accepted start.
- lock  out  1  final result within tolerance; valid when done=1.
- err  out  1  measurement timeout occurred; valid when done=1.

Behaviour:
- Reset values: cap_code = mid (1000 for CODE_W=4); meas_start, busy, done, lock, err = 0; state IDLE; all counters 0.
- rst asserted mid-run returns every output to its reset value on the next edge. No measurement is pending afterwards, and a late meas_done is ignored.
- States: IDLE, SETTLE, TRIG, WAIT, DONE.
- IDLE/DONE, start=1:
  - Latch target_cnt; cap_code = mid; bit pointer = MSB; verify flag = 0.
  - Clear done, lock and err; busy = 1; go to SETTLE.
- start is ignored in SETTLE, TRIG and WAIT.
- SETTLE: count SETTLE_CYC cycles, then go to TRIG.
- TRIG: meas_start = 1 for exactly this one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - meas_done is acted on only in this state; it is ignored in every other state.
  - The decision is taken on the edge where meas_done = 1.
  - diff = |meas_cnt - target| is computed at CNT_W+1 bits, unsigned, with no wrap.
  - If diff <= TOL: lock = 1, done = 1, busy = 0, go to DONE; cap_code is unchanged.
  - Else if the verify flag is set: lock = 0, done = 1, go to DONE.
  - Else slow (meas_cnt < target): keep the current bit.
  - Else fast (meas_cnt > target): clear the current bit.
  - After a slow or fast decision, if the pointer is above bit 0: set the next lower bit, decrement the pointer, go to SETTLE.
  - If the pointer is at bit 0: apply the decision only (no new bit set), set the verify flag, go to SETTLE.
  - If the timeout counter reaches TIMEOUT_CYC without meas_done: err = 1, lock = 0, done = 1, busy = 0, go to DONE; cap_code holds its last value.
- Latency (no timeout): a run has at most CODE_W+1 measurements. Each step costs SETTLE_CYC + 1 (TRIG) + the counter response time.
- DONE: outputs hold, and cap_code is frozen until the next start or rst.

Test Plan:
1. CODE_W=4, SETTLE_CYC=4, target=1000; answer meas_cnt=1000 at the first meas_done -> one meas_start pulse, cap_code=1000, lock=1, done=1, err=0.
2. Always answer 900 (slow) -> cap_code sequence 1000, 1100, 1110, 1111, then a verify measurement at 1111.
   - Verify answer 999 -> lock=1.
   - Verify answer 900 -> lock=0, done=1.
   - Exactly 5 meas_start pulses, each preceded by at least 4 settle cycles.
3. Always answer 1100 (fast) -> codes 1000, 0100, 0010, 0001, then 0000 at verify; lock=0, done=1.
4. Tolerance boundary, target=1000:
   - meas_cnt=1002 and 998 -> lock on the first step.
   - 1003 -> treated as fast, cap_code becomes 0100.
5. Never assert meas_done -> after TIMEOUT_CYC cycles in WAIT: err=1, done=1, lock=0, busy=0, no further meas_start.
6. Control-edge cases:
   - start pulsed during SETTLE or WAIT -> ignored.
   - meas_done pulsed during SETTLE -> ignored.
   - rst asserted in WAIT -> next cycle cap_code=1000 and all flags 0.
   - Then start with target=1000 -> a fresh run begins.
